fft_input_reorder: RTL

Input stage of the 8-point FFT, directly upstream of the first butterfly column. It accepts complex samples one per cycle over a valid/ready stream. It stores each sample at its bit-reversed index in a ping-pong (two-bank) buffer and presents a completed frame as parallel buses to the stage-1 butterflies. Double buffering lets frame k+1 load while frame k is held for downstream.

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_input_reorder_if.sv | 30 +++
 rtl/fft_input_reorder_bank.sv | 41 ++++
 rtl/fft_input_reorder.sv | 118 +++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: default widths, bank state
// encoding and the bit-reversal index helper.
package fft_pkg;

    localparam int FFT_N       = 3;
    localparam int FFT_LOG_PTS = 3;
    localparam int FFT_W       = 2 ** FFT_N;
    localparam int FFT_PTS     = 2 ** FFT_LOG_PTS;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Reverse the low log_pts bits of k; upper bits of the result are zero.
    function automatic int bitrev(input int k, input int log_pts);
        int r;
        r = 0;
        for (int i = 0; i < log_pts; i++) begin
            r[i] = k[log_pts - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_input_reorder_if.sv
// Sample-in / frame-out stream bundle for the FFT input reorder stage.
// slave is the reorder block, master is whoever drives samples and
// consumes frames.
interface fft_input_reorder_if
    import fft_pkg::*;
#(
    parameter int W   = FFT_W,
    parameter int PTS = FFT_PTS
);

    logic                  in_valid;
    logic                  in_ready;
    logic signed [W-1:0]   in_r;
    logic signed [W-1:0]   in_i;
    logic                  out_valid;
    logic                  out_ready;
    logic [PTS*W-1:0]      out_r;
    logic [PTS*W-1:0]      out_i;

    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_r, out_i
    );

    modport master (
        output in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_r, out_i
    );

endinterface

// File: rtl/fft_input_reorder_bank.sv
// One bank of the ping-pong reorder buffer: PTS complex words with a
// single write port and the whole contents exposed as flat buses.
module reorder_bank
    import fft_pkg::*;
#(
    parameter int W   = FFT_W,
    parameter int PTS = FFT_PTS,
    parameter int AW  = FFT_LOG_PTS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [AW-1:0]       addr_i,
    input  logic signed [W-1:0] wr_r_i,
    input  logic signed [W-1:0] wr_i_i,
    output logic [PTS*W-1:0]    rd_r_o,
    output logic [PTS*W-1:0]    rd_i_o
);

    logic signed [W-1:0] mem_r_q [PTS];
    logic signed [W-1:0] mem_i_q [PTS];

    // Sample storage; cleared on reset so the frame buses come up at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PTS; k++) begin
                mem_r_q[k] <= '0;
                mem_i_q[k] <= '0;
            end
        end else if (we_i) begin
            mem_r_q[addr_i] <= wr_r_i;
            mem_i_q[addr_i] <= wr_i_i;
        end
    end

    for (genvar k = 0; k < PTS; k++) begin : g_flat
        assign rd_r_o[k*W +: W] = mem_r_q[k];
        assign rd_i_o[k*W +: W] = mem_i_q[k];
    end

endmodule

// File: rtl/fft_input_reorder.sv
// FFT input stage: stores incoming samples at bit-reversed addresses in a
// two-bank ping-pong buffer and hands complete frames to the butterflies
// as parallel buses. One bank fills while the other is held for output.
module fft_input_reorder
    import fft_pkg::*;
#(
    parameter int N       = FFT_N,
    parameter int LOG_PTS = FFT_LOG_PTS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    fft_input_reorder_if.slave bus
);

    localparam int W   = 2 ** N;
    localparam int PTS = 2 ** LOG_PTS;

    logic [LOG_PTS-1:0] cnt_q, cnt_d;
    logic               wb_q, wb_d;
    logic               rb_q, rb_d;
    bank_state_e        st_q [2];
    bank_state_e        st_d [2];

    logic               accept;
    logic               drain;
    logic               wrap;
    logic [LOG_PTS-1:0] wr_addr;
    logic               we0, we1;
    logic [PTS*W-1:0]   bank0_r, bank0_i, bank1_r, bank1_i;

    // Handshake decode: the write bank may take samples unless it is already
    // full; the read bank is offered downstream once full.
    always_comb begin
        bus.in_ready  = (st_q[wb_q] != BANK_FULL);
        bus.out_valid = (st_q[rb_q] == BANK_FULL);
        accept        = bus.in_valid && bus.in_ready;
        drain         = bus.out_valid && bus.out_ready;
        wrap          = (cnt_q == LOG_PTS'(PTS - 1));
        wr_addr       = LOG_PTS'(bitrev(int'(cnt_q), LOG_PTS));
        we0           = accept && !clear && (wb_q == 1'b0);
        we1           = accept && !clear && (wb_q == 1'b1);
    end

    // Next-state for counter, pointers and per-bank state. Fill and drain
    // always hit different banks, so both updates are applied independently.
    always_comb begin
        cnt_d    = cnt_q;
        wb_d     = wb_q;
        rb_d     = rb_q;
        st_d[0]  = st_q[0];
        st_d[1]  = st_q[1];
        if (clear) begin
            cnt_d   = '0;
            wb_d    = 1'b0;
            rb_d    = 1'b0;
            st_d[0] = BANK_EMPTY;
            st_d[1] = BANK_EMPTY;
        end else begin
            if (accept) begin
                cnt_d = cnt_q + LOG_PTS'(1);
                if (wrap) begin
                    st_d[wb_q] = BANK_FULL;
                    wb_d       = ~wb_q;
                end else begin
                    st_d[wb_q] = BANK_FILLING;
                end
            end
            if (drain) begin
                st_d[rb_q] = BANK_EMPTY;
                rb_d       = ~rb_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
            st_q[0] <= BANK_EMPTY;
            st_q[1] <= BANK_EMPTY;
        end else begin
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            st_q[0] <= st_d[0];
            st_q[1] <= st_d[1];
        end
    end

    reorder_bank #(.W(W), .PTS(PTS), .AW(LOG_PTS)) u_bank0 (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we0),
        .addr_i (wr_addr),
        .wr_r_i (bus.in_r),
        .wr_i_i (bus.in_i),
        .rd_r_o (bank0_r),
        .rd_i_o (bank0_i)
    );

    reorder_bank #(.W(W), .PTS(PTS), .AW(LOG_PTS)) u_bank1 (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we1),
        .addr_i (wr_addr),
        .wr_r_i (bus.in_r),
        .wr_i_i (bus.in_i),
        .rd_r_o (bank1_r),
        .rd_i_o (bank1_i)
    );

    assign bus.out_r = rb_q ? bank1_r : bank0_r;
    assign bus.out_i = rb_q ? bank1_i : bank0_i;

endmodule
